// File: rtl/gshare_predictor.sv
// Bimodal / gshare branch direction predictor: a table of saturating counters,
// self-initialised after reset, with a registered prediction and separate update port.
module gshare_predictor #(
  parameter int PC_W     = 32,
  parameter int IDX_BITS = 6,
  parameter int CTR_BITS = 2,
  parameter int GHR_BITS = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mode,
  output logic                ready,
  input  logic                req_valid,
  input  logic [PC_W-1:0]     req_pc,
  output logic                pred_valid,
  output logic                pred_taken,
  output logic [IDX_BITS-1:0] pred_idx,
  output logic [CTR_BITS-1:0] pred_ctr,
  input  logic                upd_valid,
  input  logic [IDX_BITS-1:0] upd_idx,
  input  logic                upd_taken,
  output logic [GHR_BITS-1:0] ghr
);

  localparam int DEPTH = 1 << IDX_BITS;
  localparam logic [CTR_BITS-1:0] INIT_VAL = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;

  typedef enum logic {INIT, RUN} state_t;

  state_t              state, state_nxt;
  logic [IDX_BITS-1:0] init_cnt;
  logic [CTR_BITS-1:0] ctr_table [DEPTH];
  logic [IDX_BITS-1:0] pc_idx, ghr_ext, req_idx;
  logic [CTR_BITS-1:0] upd_ctr, upd_ctr_nxt;
  logic [GHR_BITS:0]   ghr_shift;
  logic                req_accept, upd_accept;
  logic                unused_pc_bits;

  assign ready          = (state == RUN);
  assign req_accept     = ready && req_valid;
  assign upd_accept     = ready && upd_valid;
  assign unused_pc_bits = ^{req_pc[PC_W-1:IDX_BITS+2], req_pc[1:0]};

  always_comb begin
    state_nxt = state;
    if (state == INIT && (&init_cnt)) state_nxt = RUN;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= INIT;
      init_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == INIT) init_cnt <= init_cnt + 1'b1;
    end
  end

  // History is zero-extended to the index width before the XOR.
  always_comb begin
    ghr_ext                = '0;
    ghr_ext[GHR_BITS-1:0]  = ghr;
    pc_idx                 = req_pc[IDX_BITS+1:2];
    req_idx                = mode ? (pc_idx ^ ghr_ext) : pc_idx;
  end

  always_comb begin
    upd_ctr     = ctr_table[upd_idx];
    upd_ctr_nxt = upd_ctr;
    if (upd_taken && upd_ctr != CTR_MAX)
      upd_ctr_nxt = upd_ctr + 1'b1;
    else if (!upd_taken && upd_ctr != '0)
      upd_ctr_nxt = upd_ctr - 1'b1;
    ghr_shift = {ghr, upd_taken};
  end

  // Table writes land on the edge, so a same-cycle read sees the old counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == INIT)
        ctr_table[init_cnt] <= INIT_VAL;
      else if (upd_valid)
        ctr_table[upd_idx] <= upd_ctr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
      pred_idx   <= '0;
      pred_ctr   <= '0;
      ghr        <= '0;
    end else begin
      pred_valid <= req_accept;
      if (req_accept) begin
        pred_idx   <= req_idx;
        pred_ctr   <= ctr_table[req_idx];
        pred_taken <= ctr_table[req_idx][CTR_BITS-1];
      end
      if (upd_accept) ghr <= ghr_shift[GHR_BITS-1:0];
    end
  end

endmodule
